// File: rtl/m_mem_access_unit_pkg.sv
// m_mem_access_unit_pkg: access-size encodings, FSM states and lane helpers
package m_mem_access_unit_pkg;
  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;
  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;
  function automatic logic [7:0] lane_mask(input logic [1:0] sz);
    return sz == SZ_BYTE ? 8'h01 : sz == SZ_HALF ? 8'h03 : sz == SZ_WORD ? 8'h0F : 8'hFF;
  endfunction
  function automatic logic [2:0] align_mask(input logic [1:0] sz);
    return sz == SZ_BYTE ? 3'b000 : sz == SZ_HALF ? 3'b001 : sz == SZ_WORD ? 3'b011 : 3'b111;
  endfunction
endpackage

// File: rtl/m_mem_access_unit_load_extend.sv
// m_load_extend: shifts the addressed lanes down and sign/zero-extends the load result
module m_load_extend import m_mem_access_unit_pkg::*; #(
  parameter int DATA_W = 32,
  localparam int OB = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [OB-1:0]     off,
  input  logic [1:0]        size,
  input  logic              uns,
  output logic [DATA_W-1:0] data
);
  logic [DATA_W-1:0] sh, keep, sbit;
  logic [6:0] w, wc;
  always_comb begin
    sh = rdata >> {off, 3'b000};
    w = size == SZ_DWORD ? 7'd64 : 7'd8 << size;
    wc = w > 7'(DATA_W) ? 7'(DATA_W) : w;
    keep = ~({DATA_W{1'b1}} << wc);
    sbit = DATA_W'(1'b1) << (wc - 7'd1);
    data = (sh & keep) | ({DATA_W{~uns & |(sh & sbit)}} & ~keep);
  end
endmodule

// File: rtl/m_mem_access_unit.sv
// m_mem_access_unit: M-stage data-memory request/ack unit with lane steering, stall and exceptions
module m_mem_access_unit import m_mem_access_unit_pkg::*; #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  M_valid,
  input  logic                  M_load,
  input  logic                  M_store,
  input  logic [1:0]            M_size,
  input  logic                  M_unsigned,
  input  logic [ADDR_W-1:0]     M_addr,
  input  logic [DATA_W-1:0]     M_wdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_byteen,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [DATA_W-1:0]     M_load_data,
  output logic                  M_stall,
  output logic                  M_exc_adel,
  output logic                  M_exc_ades,
  output logic                  M_exc_bus
);
  localparam int NB = DATA_W / 8;
  localparam int OB = $clog2(NB);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] addr_q, addr_l;
  logic [NB-1:0] be_q, be_l;
  logic [DATA_W-1:0] wd_q, wd_l;
  logic [OB-1:0] off, off_q, ext_off;
  logic [1:0] size_q, ext_size;
  logic we_q, uns_q, ext_uns, mis, go, wt, hit;
  assign off = M_addr[OB-1:0];
  assign mis = |(M_addr[2:0] & align_mask(M_size));
  assign go = M_valid & (M_load | M_store) & ~mis;
  assign wt = state == ST_WAIT;
  assign hit = TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
  assign addr_l = {M_addr[ADDR_W-1:OB], {OB{1'b0}}};
  assign be_l = M_store ? NB'(lane_mask(M_size)) << off : '0;
  assign wd_l = M_wdata << {off, 3'b000};
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else state <= nxt;
  end
  always_comb nxt = wt ? (mem_ack | hit ? ST_IDLE : ST_WAIT) : (go & ~mem_ack ? ST_WAIT : ST_IDLE);
  // request fields are frozen on entry to WAIT so the bus sees a stable request
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      addr_q <= '0;
      be_q <= '0;
      wd_q <= '0;
      we_q <= 1'b0;
      off_q <= '0;
      size_q <= '0;
      uns_q <= 1'b0;
    end else if (!wt && go && !mem_ack) begin
      cnt <= '0;
      addr_q <= addr_l;
      be_q <= be_l;
      wd_q <= wd_l;
      we_q <= M_store;
      off_q <= off;
      size_q <= M_size;
      uns_q <= M_unsigned;
    end else if (wt && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end
  always_comb begin
    mem_req = ~reset & (wt | go);
    mem_we = ~reset & (wt ? we_q : go & M_store);
    mem_addr = wt ? addr_q : addr_l;
    mem_byteen = wt ? be_q : be_l;
    mem_wdata = wt ? wd_q : wd_l;
    ext_off = wt ? off_q : off;
    ext_size = wt ? size_q : M_size;
    ext_uns = wt ? uns_q : M_unsigned;
    M_stall = ~reset & ~mem_ack & (wt ? ~hit : go);
    M_exc_adel = ~reset & ~wt & M_valid & M_load & mis;
    M_exc_ades = ~reset & ~wt & M_valid & M_store & mis;
    M_exc_bus = ~reset & wt & ~mem_ack & hit;
  end
  m_load_extend #(.DATA_W(DATA_W)) u_ext (
    .rdata(mem_rdata),
    .off(ext_off),
    .size(ext_size),
    .uns(ext_uns),
    .data(M_load_data)
  );
endmodule

// File: tb/tb_m_mem_access_unit.sv
// tb_m_mem_access_unit: randomized transaction-level check of 32-bit (TIMEOUT=4) and 64-bit instances
module tb_m_mem_access_unit;
  localparam int T = 4;
  logic clk = 0, reset = 1, valid = 0, ld = 0, st = 0, uns = 0, ack = 0, ack64 = 1;
  logic [1:0] size = 0;
  logic [31:0] addr = 0, wdata = 0, rdata = 0;
  logic [63:0] wdata64 = 0, rdata64 = 0;
  logic req, we, stall, adel, ades, bus;
  logic [31:0] maddr, mwd, ldata;
  logic [3:0] be;
  logic req64, we64, stall64, adel64, ades64, bus64;
  logic [31:0] maddr64;
  logic [63:0] mwd64, ldata64;
  logic [7:0] be64;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  m_mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(T)) u32 (
    .clk(clk), .reset(reset), .M_valid(valid), .M_load(ld), .M_store(st), .M_size(size),
    .M_unsigned(uns), .M_addr(addr), .M_wdata(wdata), .mem_req(req), .mem_we(we),
    .mem_addr(maddr), .mem_byteen(be), .mem_wdata(mwd), .mem_ack(ack), .mem_rdata(rdata),
    .M_load_data(ldata), .M_stall(stall), .M_exc_adel(adel), .M_exc_ades(ades), .M_exc_bus(bus)
  );
  m_mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(16)) u64 (
    .clk(clk), .reset(reset), .M_valid(valid), .M_load(ld), .M_store(st), .M_size(size),
    .M_unsigned(uns), .M_addr(addr), .M_wdata(wdata64), .mem_req(req64), .mem_we(we64),
    .mem_addr(maddr64), .mem_byteen(be64), .mem_wdata(mwd64), .mem_ack(ack64), .mem_rdata(rdata64),
    .M_load_data(ldata64), .M_stall(stall64), .M_exc_adel(adel64), .M_exc_ades(ades64), .M_exc_bus(bus64)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [63:0] extend(input logic [63:0] rd, input int o, input int sz, input bit u);
    logic [63:0] r, m;
    int w;
    w = 8 << sz;
    r = rd >> (8 * o);
    if (w < 64) begin
      m = (64'd1 << w) - 64'd1;
      r = r & m;
      if (!u && r[w-1]) r = r | ~m;
    end
    return r;
  endfunction
  // one access on the 32-bit unit: memory answers after lat cycles (lat > T means never)
  task automatic run_txn(input bit is_ld, input int sz, input logic [31:0] a, input logic [31:0] wd,
                         input bit u, input int lat, input logic [31:0] rd);
    bit mis;
    int o, n;
    logic [31:0] e_addr, e_wd;
    logic [3:0] e_be;
    logic [63:0] e_ld;
    mis = (a & ((32'd1 << sz) - 32'd1)) != 0;
    o = int'(a % 4);
    e_addr = a - 32'(o);
    e_be = is_ld ? 4'd0 : 4'(((1 << (1 << sz)) - 1) << o);
    e_wd = wd << (8 * o);
    e_ld = extend({32'd0, rd}, o, sz, u) & 64'hFFFF_FFFF;
    n = mis ? 0 : (lat <= T ? lat : T);
    for (int k = 0; k <= n; k++) begin
      valid = 1; ld = is_ld; st = !is_ld;
      if (k == 0) begin
        size = 2'(sz); addr = a; wdata = wd; uns = u;
      end else begin
        size = 2'($urandom_range(0, 2)); addr = $urandom; wdata = $urandom; uns = 1'($urandom);
      end
      ack = !mis && k == lat;
      rdata = ack ? rd : $urandom;
      @(negedge clk);
      check("req", req, !mis);
      check("stall", stall, k < n);
      check("adel", adel, mis && is_ld);
      check("ades", ades, mis && !is_ld);
      check("bus", bus, !mis && lat > T && k == T);
      if (!mis) begin
        check("we", we, !is_ld);
        check("addr", maddr, e_addr);
        check("byteen", be, e_be);
        check("wdata", mwd, e_wd);
        if (is_ld && ack) check("ldata", ldata, e_ld);
      end
      step();
    end
    valid = 0; ld = 0; st = 0; ack = 1'($urandom);
    @(negedge clk);
    check("idle_req", req, 0);
    check("idle_stall", stall, 0);
    check("idle_bus", bus, 0);
    step();
  endtask
  // zero-wait access on the 64-bit unit
  task automatic zw64(input bit is_ld, input int sz, input logic [31:0] a, input logic [63:0] wd,
                      input bit u, input logic [63:0] rd);
    int o;
    logic [7:0] e_be;
    o = int'(a % 8);
    e_be = is_ld ? 8'd0 : 8'(((1 << (1 << sz)) - 1) << o);
    valid = 1; ld = is_ld; st = !is_ld; size = 2'(sz); addr = a; uns = u;
    wdata64 = wd; wdata = wd[31:0]; rdata64 = rd; ack = 1;
    @(negedge clk);
    check("req64", req64, 1);
    check("stall64", stall64, 0);
    check("we64", we64, !is_ld);
    check("addr64", maddr64, a - 32'(o));
    check("byteen64", be64, e_be);
    check("wdata64", mwd64, wd << (8 * o));
    if (is_ld) check("ldata64", ldata64, extend(rd, o, sz, u));
    step();
    valid = 0; ld = 0; st = 0;
  endtask
  initial begin
    bit is_ld, u;
    int sz, lat;
    logic [31:0] a;
    valid = 1; ld = 1; size = 2; addr = 32'h10; ack = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_req", req, 0);
      check("rst_stall", stall, 0);
      check("rst_we", we, 0);
      step();
    end
    reset = 0; valid = 0; ld = 0;
    @(negedge clk);
    check("post_rst_req", req, 0);
    check("post_rst_stall", stall, 0);
    step();
    run_txn(0, 0, 32'h1003, 32'hAB, 0, 0, 0);
    run_txn(1, 1, 32'h2002, 0, 0, 3, 32'h8001_1234);
    run_txn(1, 1, 32'h2002, 0, 1, 3, 32'h8001_1234);
    run_txn(1, 2, 32'h0006, 0, 0, 0, 0);
    run_txn(0, 1, 32'h0001, 0, 0, 0, 0);
    run_txn(0, 2, 32'h0040, 32'hDEAD_BEEF, 0, 10, 0);
    run_txn(1, 2, 32'h0044, 0, 0, T, 32'h1234_5678);
    valid = 1; ld = 0; st = 1; size = 2; addr = 32'h100; wdata = 32'h55AA_1234; ack = 0;
    @(negedge clk);
    check("rw_stall0", stall, 1);
    step();
    addr = 32'h777; wdata = 0;
    @(negedge clk);
    check("rw_req1", req, 1);
    check("rw_addr1", maddr, 32'h100);
    step();
    reset = 1;
    @(negedge clk);
    check("rw_rst_req", req, 0);
    check("rw_rst_stall", stall, 0);
    step();
    reset = 0; valid = 0; st = 0;
    @(negedge clk);
    check("rw_after_req", req, 0);
    check("rw_after_stall", stall, 0);
    step();
    run_txn(1, 0, 32'h0203, 0, 0, 0, 32'h8000_0000);
    for (int i = 0; i < 60; i++) begin
      is_ld = 1'($urandom); u = 1'($urandom);
      sz = $urandom_range(0, 2); lat = $urandom_range(0, 6);
      a = $urandom;
      if ($urandom_range(0, 4) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      run_txn(is_ld, sz, a, $urandom, u, lat, $urandom);
    end
    zw64(0, 3, 32'h0000_1008, 64'h0123_4567_89AB_CDEF, 0, 0);
    zw64(1, 2, 32'h0000_1004, 0, 0, 64'h8000_0000_1234_5678);
    zw64(1, 2, 32'h0000_1004, 0, 1, 64'h8000_0000_1234_5678);
    for (int i = 0; i < 20; i++) begin
      sz = $urandom_range(0, 3);
      a = $urandom & ~((32'd1 << sz) - 32'd1);
      zw64(1'($urandom), sz, a, {$urandom, $urandom}, 1'($urandom), {$urandom, $urandom});
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
